// File: rtl/melody_seq.sv
// -----------------------------------------------------------------------------
// melody_seq
//   Note sequencer feeding the note_bin input of the DDS tone generator.
//   Steps through a fixed 42-entry melody ROM (six phrases of seven notes).
//   Each entry is held for units*TICK_DIV clock cycles.
//
//   Optional feature: define NOTE_GAP_EN to insert a rest of GAP_CYC cycles
//   (note_bin = 0) after every note. Without it, notes are played legato, the
//   GAP state is absent and GAP_CYC is unused.
//
// Parameters
//   TICK_DIV : clk cycles per beat unit (>= 1, 2*TICK_DIV < 2^32)
//   GAP_CYC  : rest cycles after each note (NOTE_GAP_EN only, >= 1)
//
// Ports
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   start    : begin playback from entry 0 (honoured only when idle)
//   stop     : abort playback (stop wins over start)
//   note_bin : note code to the DDS, 0 = silence, 1..7 = scale degree
//   busy     : high while a song is in progress
//   done     : one-cycle pulse when the last entry completes normally
//   idx      : current ROM entry index, 0..41
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module melody_seq #(
    parameter int unsigned TICK_DIV = 1000000,
    parameter int unsigned GAP_CYC  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    output logic [2:0] note_bin,
    output logic       busy,
    output logic       done,
    output logic [5:0] idx
);

    // Elaboration-time parameter sanity checks.
    generate
        if (TICK_DIV < 1) begin : g_bad_tick
            $error("melody_seq: TICK_DIV must be >= 1");
        end
        if (GAP_CYC < 1) begin : g_bad_gap
            $error("melody_seq: GAP_CYC must be >= 1");
        end
    endgenerate

    localparam logic [5:0] LAST_IDX = 6'd41;

    // Terminal counts for one- and two-unit notes.
    localparam logic [31:0] TC_ONE = 32'(TICK_DIV - 1);
    localparam logic [31:0] TC_TWO = 32'((2 * TICK_DIV) - 1);
`ifdef NOTE_GAP_EN
    localparam logic [31:0] TC_GAP = 32'(GAP_CYC - 1);
`endif

    // Entry format {note[2:0], units[1:0]}; phrase order A B C C A B.
    localparam logic [4:0] ROM [0:41] = '{
        {3'd1, 2'd1}, {3'd1, 2'd1}, {3'd5, 2'd1}, {3'd5, 2'd1}, {3'd6, 2'd1}, {3'd6, 2'd1}, {3'd5, 2'd2},
        {3'd4, 2'd1}, {3'd4, 2'd1}, {3'd3, 2'd1}, {3'd3, 2'd1}, {3'd2, 2'd1}, {3'd2, 2'd1}, {3'd1, 2'd2},
        {3'd5, 2'd1}, {3'd5, 2'd1}, {3'd4, 2'd1}, {3'd4, 2'd1}, {3'd3, 2'd1}, {3'd3, 2'd1}, {3'd2, 2'd2},
        {3'd5, 2'd1}, {3'd5, 2'd1}, {3'd4, 2'd1}, {3'd4, 2'd1}, {3'd3, 2'd1}, {3'd3, 2'd1}, {3'd2, 2'd2},
        {3'd1, 2'd1}, {3'd1, 2'd1}, {3'd5, 2'd1}, {3'd5, 2'd1}, {3'd6, 2'd1}, {3'd6, 2'd1}, {3'd5, 2'd2},
        {3'd4, 2'd1}, {3'd4, 2'd1}, {3'd3, 2'd1}, {3'd3, 2'd1}, {3'd2, 2'd1}, {3'd2, 2'd1}, {3'd1, 2'd2}
    };

`ifdef NOTE_GAP_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1
    } state_t;
`endif

    state_t      state_reg;
    logic [31:0] cnt_reg;

    // Look-ups for the current entry and the one after it. next_idx is only
    // used when idx < 41, so it always addresses a valid entry.
    logic [5:0]  next_idx;
    logic [4:0]  cur_entry;
    logic [4:0]  next_entry;
    logic [31:0] play_tc;
    logic        is_last;

    always_comb begin
        next_idx   = idx + 6'd1;
        cur_entry  = ROM[idx];
        next_entry = ROM[next_idx];
        play_tc    = (cur_entry[1:0] == 2'd2) ? TC_TWO : TC_ONE;
        is_last    = (idx == LAST_IDX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 32'd0;
            idx       <= 6'd0;
            note_bin  <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !stop) begin
                        state_reg <= PLAY;
                        cnt_reg   <= 32'd0;
                        idx       <= 6'd0;
                        note_bin  <= ROM[0][4:2];
                        busy      <= 1'b1;
                    end
                end

                PLAY: begin
                    if (stop) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 32'd0;
                        idx       <= 6'd0;
                        note_bin  <= 3'd0;
                        busy      <= 1'b0;
                    end else if (cnt_reg == play_tc) begin
                        cnt_reg <= 32'd0;
`ifdef NOTE_GAP_EN
                        // Every note, including the last, is followed by a rest.
                        state_reg <= GAP;
                        note_bin  <= 3'd0;
`else
                        if (is_last) begin
                            state_reg <= IDLE;
                            idx       <= 6'd0;
                            note_bin  <= 3'd0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx      <= next_idx;
                            note_bin <= next_entry[4:2];
                        end
`endif
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end

`ifdef NOTE_GAP_EN
                GAP: begin
                    if (stop) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 32'd0;
                        idx       <= 6'd0;
                        note_bin  <= 3'd0;
                        busy      <= 1'b0;
                    end else if (cnt_reg == TC_GAP) begin
                        cnt_reg <= 32'd0;
                        if (is_last) begin
                            state_reg <= IDLE;
                            idx       <= 6'd0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= PLAY;
                            idx       <= next_idx;
                            note_bin  <= next_entry[4:2];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
`endif

                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= 32'd0;
                    idx       <= 6'd0;
                    note_bin  <= 3'd0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_melody_seq.sv
// -----------------------------------------------------------------------------
// tb_melody_seq
//   Self-checking bench for melody_seq with TICK_DIV = 4, GAP_CYC = 2.
//   A timeline model tracks cycles elapsed since playback began and derives
//   the expected entry/note by walking the song's note and rest durations.
//   Directed scenarios are followed by a randomized start/stop/rst phase.
// -----------------------------------------------------------------------------
module tb_melody_seq;

    localparam int TICK = 4;
    localparam int GAPC = 2;
`ifdef NOTE_GAP_EN
    localparam int HAS_GAP = 1;
`else
    localparam int HAS_GAP = 0;
`endif
    // 48 beat units in total, plus one rest per entry when rests are enabled.
    localparam int SONG_LEN = 48 * TICK + HAS_GAP * 42 * GAPC;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [2:0] note_bin;
    logic       busy;
    logic       done;
    logic [5:0] idx;

    melody_seq #(
        .TICK_DIV (TICK),
        .GAP_CYC  (GAPC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .note_bin (note_bin),
        .busy     (busy),
        .done     (done),
        .idx      (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int phrase_notes [3][7] = '{'{1, 1, 5, 5, 6, 6, 5},
                                '{4, 4, 3, 3, 2, 2, 1},
                                '{5, 5, 4, 4, 3, 3, 2}};
    int phrase_order [6] = '{0, 1, 2, 2, 0, 1};

    bit m_playing = 0;
    int m_elapsed = 0;
    bit m_done    = 0;

    function automatic int song_note(input int k);
        return phrase_notes[phrase_order[k / 7]][k % 7];
    endfunction

    function automatic int song_units(input int k);
        return ((k % 7) == 6) ? 2 : 1;
    endfunction

    // Which entry / note sounds e cycles after playback began.
    function automatic void seg_at(input int e, output int e_idx, output int e_note);
        int rem;
        rem    = e;
        e_idx  = 0;
        e_note = 0;
        for (int k = 0; k < 42; k++) begin
            if (rem < song_units(k) * TICK) begin
                e_idx  = k;
                e_note = song_note(k);
                return;
            end
            rem -= song_units(k) * TICK;
            if (HAS_GAP != 0) begin
                if (rem < GAPC) begin
                    e_idx  = k;
                    e_note = 0;
                    return;
                end
                rem -= GAPC;
            end
        end
    endfunction

    function automatic void expected(output int e_idx, output int e_note,
                                     output int e_busy, output int e_done);
        if (m_playing) begin
            seg_at(m_elapsed, e_idx, e_note);
            e_busy = 1;
            e_done = 0;
        end else begin
            e_idx  = 0;
            e_note = 0;
            e_busy = 0;
            e_done = int'(m_done);
        end
    endfunction

    function automatic void model_edge();
        if (rst) begin
            m_playing = 0;
            m_done    = 0;
        end else if (m_playing) begin
            m_done = 0;
            if (stop) begin
                m_playing = 0;
            end else if (m_elapsed + 1 == SONG_LEN) begin
                m_playing = 0;
                m_done    = 1;
            end else begin
                m_elapsed++;
            end
        end else begin
            m_done = 0;
            if (start && !stop) begin
                m_playing = 1;
                m_elapsed = 0;
            end
        end
    endfunction

    task automatic compare_all();
        int e_idx, e_note, e_busy, e_done;
        expected(e_idx, e_note, e_busy, e_done);
        check("note_bin", int'(note_bin), e_note);
        check("idx", int'(idx), e_idx);
        check("busy", int'(busy), e_busy);
        check("done", int'(done), e_done);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    function automatic int model_idx();
        int e_idx, e_note, e_busy, e_done;
        expected(e_idx, e_note, e_busy, e_done);
        return e_idx;
    endfunction

    function automatic int model_note();
        int e_idx, e_note, e_busy, e_done;
        expected(e_idx, e_note, e_busy, e_done);
        return e_note;
    endfunction

    task automatic wait_idx(input int target);
        int n;
        n = 0;
        while (!(m_playing && model_idx() == target) && n < 2000) begin
            tick();
            n++;
        end
        check("wait_idx", int'(idx), target);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        #1;
        compare_all();
        $display("reset: note_bin=%0d busy=%0d done=%0d idx=%0d", note_bin, busy, done, idx);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Full song: done must land SONG_LEN+1 edges after the start edge.
        pulse_start();
        check("first_note", int'(note_bin), 1);
        cnt = 1;
        while (!done && cnt < 1000) begin
            tick();
            cnt++;
        end
        check("song_len", cnt, SONG_LEN + 1);
        check("done_busy", int'(busy), 0);
        $display("full song: done after %0d edges", cnt);
        repeat (3) tick();

        // Stop at idx 10, then restart from entry 0.
        pulse_start();
        wait_idx(10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_note", int'(note_bin), 0);
        check("stop_busy", int'(busy), 0);
        repeat (4) tick();
        pulse_start();
        check("restart_idx", int'(idx), 0);
        check("restart_note", int'(note_bin), 1);
        $display("stop at idx 10 and restart");

        // start while busy is ignored.
        wait_idx(3);
        pulse_start();
        wait_idx(4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        $display("start while busy ignored");

        // start and stop together in IDLE: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_busy", int'(busy), 0);
        tick();
        $display("start+stop in idle");

        // Asynchronous reset in the rest after entry 20 (note 20 when legato).
        pulse_start();
        wait_idx(20);
        cnt = 0;
        while (HAS_GAP != 0 && model_note() != 0 && cnt < 100) begin
            tick();
            cnt++;
        end
        #2;
        rst = 1'b1;
        #1;
        m_playing = 0;
        m_done    = 0;
        check("async_rst_note", int'(note_bin), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_idx", int'(idx), 0);
        check("async_rst_done", int'(done), 0);
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        check("post_rst_idx", int'(idx), 0);
        check("post_rst_note", int'(note_bin), 1);
        $display("async reset at idx 20 and restart");

        // Random control traffic.
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom % 600) == 0;
            start = ($urandom % 12) == 0;
            stop  = ($urandom % 400) == 0;
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        tick();
        $display("random phase complete");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
